clk_div_bank: RTL and testbench

Parametrised multi-channel clock divider, successor to the single free-running divider counter. Keeps a free-running WIDTH-bit count for legacy consumers and adds CH independent programmable dividers, each emitting a one-cycle enable tick and a 50%-duty square output. Sits next to the top-level clock input and feeds scan, debounce, VGA-timing and AI-step logic with clock enables rather than derived clocks.

---
 rtl/clk_div_pkg.sv | 25 ++
 rtl/clk_div_chan.sv | 107 ++++++++++
 rtl/clk_div_bank.sv | 54 +++++
 tb/tb_clk_div_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clock-enable divider bank.
package clk_div_pkg;

  // Divisor every channel starts with out of reset unless overridden.
  localparam int unsigned CLK_DIV_DEF_DIV = 50000;

  // A divisor of this value parks the channel: no ticks, square output frozen.
  localparam int unsigned DIV_OFF = 0;

  // Single-bit per-channel state that leaves the channel as outputs.
  typedef struct packed {
    logic pend;  // shadow divisor written, waiting for a terminal edge
    logic tick;  // one-cycle enable pulse
    logic sq;    // 50% duty square output
  } chan_flags_t;

  // What a channel does on the coming edge, in priority order.
  typedef enum logic [1:0] {
    EV_SYNC = 2'd0,  // phase-align: restart counter, apply any pending divisor
    EV_OFF  = 2'd1,  // channel parked on a zero divisor
    EV_TERM = 2'd2,  // enabled edge at the last count of the period
    EV_RUN  = 2'd3   // ordinary edge: count if enabled, otherwise hold
  } chan_ev_t;

endpackage

// File: rtl/clk_div_chan.sv
// One programmable divider channel: counter, active/shadow divisor pair,
// registered tick and square outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int unsigned DEF_DIV = CLK_DIV_DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdiv,
  output logic             pend,
  output logic             tick,
  output logic             sq
);

  localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] OFF_D = WIDTH'(DIV_OFF);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act_div;
  logic [WIDTH-1:0] sh_div;
  chan_flags_t      fl;
  chan_ev_t         ev;
  logic             term;

  // Last count of the period; only meaningful while the divisor is non-zero.
  // The >= keeps a stray count from running away past the divisor.
  assign term = (cnt >= (act_div - WIDTH'(1)));

  // Classify the coming edge; sync outranks everything except reset.
  always_comb begin
    ev = EV_RUN;
    if (sync)
      ev = EV_SYNC;
    else if (act_div == OFF_D)
      ev = EV_OFF;
    else if (en && term)
      ev = EV_TERM;
  end

  // Counter, divisor pair and output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      act_div <= DEF_D;
      sh_div  <= DEF_D;
      fl      <= '0;
    end else begin
      case (ev)
        EV_SYNC: begin
          cnt     <= '0;
          fl.tick <= 1'b0;
          fl.sq   <= 1'b0;
          fl.pend <= 1'b0;
          // A same-cycle write wins over an older pending shadow.
          if (wr) begin
            act_div <= wdiv;
            sh_div  <= wdiv;
          end else if (fl.pend) begin
            act_div <= sh_div;
          end
        end
        EV_OFF: begin
          cnt     <= '0;
          fl.tick <= 1'b0;
          // Nothing is in flight, so a new divisor can go live at once.
          if (wr) begin
            act_div <= wdiv;
            sh_div  <= wdiv;
          end
        end
        EV_TERM: begin
          cnt     <= '0;
          fl.tick <= 1'b1;
          fl.sq   <= ~fl.sq;
          fl.pend <= 1'b0;
          // Period boundary: a write landing now bypasses the shadow.
          if (wr) begin
            act_div <= wdiv;
            sh_div  <= wdiv;
          end else if (fl.pend) begin
            act_div <= sh_div;
          end
        end
        default: begin
          if (en)
            cnt <= cnt + WIDTH'(1);
          fl.tick <= 1'b0;
          // Mid-period write: park it until the period completes.
          if (wr) begin
            sh_div  <= wdiv;
            fl.pend <= 1'b1;
          end
        end
      endcase
    end
  end

  assign pend = fl.pend;
  assign tick = fl.tick;
  assign sq   = fl.sq;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel clock-enable divider bank with a legacy free-running count.
// Each channel emits a one-cycle tick every D enabled cycles and a square
// wave of period 2*D; consumers use these as enables, never as clocks.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int          CH      = 4,
  parameter int          CHW     = 2,
  parameter int unsigned DEF_DIV = CLK_DIV_DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  output logic [CH-1:0]    cfg_pend,
  output logic [WIDTH-1:0] free_cnt,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    sq
);

  // Free-running count for legacy consumers; wraps naturally, ignores sync/cfg.
  always_ff @(posedge clk) begin
    if (rst)
      free_cnt <= '0;
    else if (en)
      free_cnt <= free_cnt + WIDTH'(1);
  end

  // One channel per index; cfg_ch values with no matching channel select nothing.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_we && (cfg_ch == CHW'(i));

    clk_div_chan #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .sync (sync),
      .wr   (wr),
      .wdiv (cfg_div),
      .pend (cfg_pend[i]),
      .tick (tick[i]),
      .sq   (sq[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: directed scenarios followed by random traffic, all
// checked against a countdown-style model of each channel.
module tb_clk_div_bank;

  localparam int WIDTH   = 8;
  localparam int CH      = 2;
  localparam int CHW     = 1;
  localparam int DEF_DIV = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             sync;
  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic [CH-1:0]    cfg_pend;
  logic [WIDTH-1:0] free_cnt;
  logic [CH-1:0]    tick;
  logic [CH-1:0]    sq;

  always #5 clk = ~clk;

  clk_div_bank #(
    .WIDTH   (WIDTH),
    .CH      (CH),
    .CHW     (CHW),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_pend (cfg_pend),
    .free_cnt (free_cnt),
    .tick     (tick),
    .sq       (sq)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model: each channel tracks its divisor and how many enabled edges remain
  // until its next tick.
  int          m_free;
  int          m_d   [CH];
  int          m_sh  [CH];
  int          m_rem [CH];
  logic [CH-1:0] m_pend, m_tick, m_sq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic model_edge(input bit r, input bit e, input bit s, input bit w,
                            input int c, input int d);
    bit hit;
    if (r) begin
      m_free = 0;
      for (int k = 0; k < CH; k++) begin
        m_d[k] = DEF_DIV; m_sh[k] = DEF_DIV; m_rem[k] = DEF_DIV;
      end
      m_pend = '0; m_tick = '0; m_sq = '0;
      return;
    end
    if (e) m_free = (m_free + 1) % (1 << WIDTH);
    for (int k = 0; k < CH; k++) begin
      hit = w && (c == k);
      if (s) begin
        if (hit) begin m_d[k] = d; m_sh[k] = d; end
        else if (m_pend[k]) m_d[k] = m_sh[k];
        m_rem[k] = m_d[k]; m_pend[k] = 1'b0; m_tick[k] = 1'b0; m_sq[k] = 1'b0;
      end else if (m_d[k] == 0) begin
        m_tick[k] = 1'b0;
        if (hit) begin m_d[k] = d; m_sh[k] = d; m_rem[k] = d; end
      end else if (e && m_rem[k] == 1) begin
        m_tick[k] = 1'b1;
        m_sq[k]   = ~m_sq[k];
        if (hit) begin m_d[k] = d; m_sh[k] = d; end
        else if (m_pend[k]) m_d[k] = m_sh[k];
        m_pend[k] = 1'b0;
        m_rem[k]  = m_d[k];
      end else begin
        m_tick[k] = 1'b0;
        if (e) m_rem[k] = m_rem[k] - 1;
        if (hit) begin m_sh[k] = d; m_pend[k] = 1'b1; end
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit s, input bit w,
                      input int c, input int d);
    rst = r; en = e; sync = s; cfg_we = w;
    cfg_ch = CHW'(c); cfg_div = WIDTH'(d);
    @(posedge clk);
    model_edge(r, e, s, w, c, d);
    #1;
    check("free_cnt", 32'(free_cnt), 32'(m_free));
    check("tick",     32'(tick),     32'(m_tick));
    check("sq",       32'(sq),       32'(m_sq));
    check("cfg_pend", 32'(cfg_pend), 32'(m_pend));
  endtask

  initial begin
    bit r_r, r_e, r_s, r_w;
    int r_c, r_d;

    // Reset held three cycles: everything cleared.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    check("rst_free", 32'(free_cnt), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_sq",   32'(sq),   32'd0);
    check("rst_pend", 32'(cfg_pend), 32'd0);

    // Default divisor 4 on both channels.
    for (int i = 1; i <= 12; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (i == 4)  begin check("e4_tick", 32'(tick), 32'd3); check("e4_sq", 32'(sq), 32'd3); end
      if (i == 5)  begin check("e5_tick", 32'(tick), 32'd0); check("e5_sq", 32'(sq), 32'd3); end
      if (i == 8)  begin check("e8_tick", 32'(tick), 32'd3); check("e8_sq", 32'(sq), 32'd0); end
      if (i == 12) check("e12_tick", 32'(tick), 32'd3);
    end

    // Shadow update on ch1 mid-period: old period finishes, then 3, 3.
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 3);
    check("shadow_pend", 32'(cfg_pend), 32'd2);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0, 0);

    // Disable ch0, then re-enable with D=2 (applied at once, no pend).
    step(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
    check("off_tick0", 32'(tick[0]), 32'd0);
    step(0, 1, 0, 1, 0, 2);
    check("on_pend0", 32'(cfg_pend[0]), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);

    // D=1 on ch0; ch1 to D=4, then en gating mid-count.
    step(0, 1, 0, 1, 0, 1);
    step(0, 1, 0, 1, 1, 4);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);

    // Sync alignment with a pending write on ch1.
    step(0, 1, 0, 1, 0, 2);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 5);
    step(0, 1, 1, 0, 0, 0);
    check("sync_sq",   32'(sq), 32'd0);
    check("sync_pend", 32'(cfg_pend), 32'd0);

    // ch0 D=2 restarted by sync: second edge is terminal, write lands on it.
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 6);
    check("coinc_pend0", 32'(cfg_pend[0]), 32'd0);
    check("coinc_tick0", 32'(tick[0]), 32'd1);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 0, 0);

    // Random traffic; long enough for free_cnt to wrap.
    for (int i = 0; i < 700; i++) begin
      r_r = ($urandom_range(0, 299) == 0);
      r_e = ($urandom_range(0, 7) != 0);
      r_s = ($urandom_range(0, 59) == 0);
      r_w = ($urandom_range(0, 5) == 0);
      r_c = int'($urandom_range(0, CH - 1));
      r_d = int'($urandom_range(0, 9));
      step(r_r, r_e, r_s, r_w, r_c, r_d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
